// File: rtl/sram_arb_pkg.sv
// Shared types for the two-client SRAM request arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_arb_pkg;

  localparam int ADDR_W_DEF = 17;
  localparam int DATA_W_DEF = 16;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Selects one of the two clients.
  typedef logic client_idx_t;

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin selector: picks the lone requester, or on a tie the client not granted last.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is taken and updates last_grant.
//
// Ports:
//   req[1:0]    request levels of client 1 / client 0
//   last_grant  client granted most recently
//   grant_valid at least one request present
//   grant_idx   selected client (meaningful only when grant_valid is high)
module sram_arb_rr
  import sram_arb_pkg::*;
(
  input  logic [1:0]  req,
  input  client_idx_t last_grant,
  output logic        grant_valid,
  output client_idx_t grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'b0;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Arbitrates two request/ack clients onto a single-outstanding SRAM controller port.
// Latency: req in IDLE -> mem_*_req next cycle; mem_ready -> client ack next cycle.
// Backpressure: a client holds req until its ack; later requests wait while a transaction is open.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cN_req/we/addr/wdata       client request level and its stable command
//   cN_ack/err/rdata           one-cycle completion pulse, timeout flag, held read data
//   mem_read_req/write_req     one-cycle command pulses to the SRAM controller
//   mem_addr/wdata             registered command, stable from ISSUE through DONE
//   mem_rdata/ready            controller read data and completion pulse
module sram_req_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_ack,
  output logic [DATA_W-1:0] c0_rdata,
  output logic              c0_err,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_ack,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              c1_err,
  output logic              mem_read_req,
  output logic              mem_write_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  state_t            state_q, state_d;
  client_idx_t       gnt_q, gnt_d;
  client_idx_t       last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] c0_rdata_q, c0_rdata_d, c1_rdata_q, c1_rdata_d;
  logic              c0_ack_q, c0_ack_d, c1_ack_q, c1_ack_d;
  logic              c0_err_q, c0_err_d, c1_err_q, c1_err_d;
  logic              mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;

  logic              rr_vld;
  client_idx_t       rr_idx;
  logic              sel_we;

  sram_arb_rr u_rr (
    .req         ({c1_req, c0_req}),
    .last_grant  (last_grant_q),
    .grant_valid (rr_vld),
    .grant_idx   (rr_idx)
  );

  // Saturating increment; the saturation value is never exceeded.
  assign cnt_inc = (cnt_q == TO_VAL) ? cnt_q : cnt_q + 1'b1;
  assign sel_we  = rr_idx ? c1_we : c0_we;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    c0_rdata_d   = c0_rdata_q;
    c1_rdata_d   = c1_rdata_q;
    // Pulse outputs default low so each is high for exactly one cycle.
    c0_ack_d     = 1'b0;
    c1_ack_d     = 1'b0;
    c0_err_d     = 1'b0;
    c1_err_d     = 1'b0;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (rr_vld) begin
          gnt_d        = rr_idx;
          last_grant_d = rr_idx;
          we_d         = sel_we;
          mem_addr_d   = rr_idx ? c1_addr : c0_addr;
          mem_wdata_d  = rr_idx ? c1_wdata : c0_wdata;
          // Command pulse is registered here so it is visible during ISSUE.
          mem_rd_d     = ~sel_we;
          mem_wr_d     = sel_we;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion in the final allowed cycle wins over the timeout.
        if (mem_ready) begin
          if (!we_q) begin
            if (gnt_q) c1_rdata_d = mem_rdata;
            else       c0_rdata_d = mem_rdata;
          end
          c0_ack_d = ~gnt_q;
          c1_ack_d = gnt_q;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_VAL) begin
            c0_ack_d = ~gnt_q;
            c1_ack_d = gnt_q;
            c0_err_d = ~gnt_q;
            c1_err_d = gnt_q;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      c0_rdata_q   <= '0;
      c1_rdata_q   <= '0;
      c0_ack_q     <= 1'b0;
      c1_ack_q     <= 1'b0;
      c0_err_q     <= 1'b0;
      c1_err_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      c0_rdata_q   <= c0_rdata_d;
      c1_rdata_q   <= c1_rdata_d;
      c0_ack_q     <= c0_ack_d;
      c1_ack_q     <= c1_ack_d;
      c0_err_q     <= c0_err_d;
      c1_err_q     <= c1_err_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
    end
  end

  assign c0_ack        = c0_ack_q;
  assign c1_ack        = c1_ack_q;
  assign c0_err        = c0_err_q;
  assign c1_err        = c1_err_q;
  assign c0_rdata      = c0_rdata_q;
  assign c1_rdata      = c1_rdata_q;
  assign mem_read_req  = mem_rd_q;
  assign mem_write_req = mem_wr_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: client drivers, SRAM controller model and an ack scoreboard.
// Latency: model answers a configurable number of cycles after each command pulse.
// Backpressure: clients hold req until ack and drop it the following cycle.
module tb_sram_req_arbiter;

  localparam int AW = 17;
  localparam int DW = 16;
  localparam int TO = 10;

  typedef struct {
    logic          cl;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            dly;    // 0 = controller never answers
    logic [DW-1:0] rret;
    logic          err;
    logic [DW-1:0] rdata;
  } vec_t;

  typedef struct {
    logic          cl;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          err;
    logic [DW-1:0] rdata;
    int            lat;
    bit            lat1;
  } exp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } job_t;

  logic          clk, rst_n;
  logic          c0_req, c0_we, c1_req, c1_we;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_wdata, c1_wdata;
  logic          c0_ack, c0_err, c1_ack, c1_err;
  logic [DW-1:0] c0_rdata, c1_rdata;
  logic          mem_read_req, mem_write_req, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   issue_cyc = 0;
  int   rise_cyc[2];
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  bit   busy = 0;
  int   mdl_delay = 1;
  logic [DW-1:0] mdl_rdata = '0;
  int   spur_cnt = 0;

  exp_t sb[$];
  job_t jq0[$];
  job_t jq1[$];
  vec_t tie_rows[0:3];
  vec_t rows[0:7];

  sram_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_ack(c0_ack), .c0_rdata(c0_rdata), .c0_err(c0_err),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_ack(c1_ack), .c1_rdata(c1_rdata), .c1_err(c1_err),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic run_row(input vec_t v, input bit lat1);
    exp_t e;
    job_t j;
    mdl_delay = v.dly;
    mdl_rdata = v.rret;
    j.we = v.we; j.addr = v.addr; j.wdata = v.wdata;
    if (v.cl) jq1.push_back(j);
    else      jq0.push_back(j);
    e.cl = v.cl; e.we = v.we; e.addr = v.addr; e.wdata = v.wdata;
    e.err = v.err; e.rdata = v.rdata;
    e.lat = (v.dly == 0) ? TO + 1 : v.dly + 1;
    e.lat1 = lat1;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while ((sb.size() != 0 || jq0.size() != 0 || jq1.size() != 0 || c0_req || c1_req)
           && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_budget", (n < max_cyc), 1);
    repeat (2) @(negedge clk);
  endtask

  // Client 0 driver
  initial begin
    job_t j;
    c0_req = 0; c0_we = 0; c0_addr = '0; c0_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) c0_req = 0;
      else if (c0_req) begin
        if (c0_ack) c0_req = 0;
      end else if (jq0.size() > 0) begin
        j = jq0.pop_front();
        c0_we = j.we; c0_addr = j.addr; c0_wdata = j.wdata;
        c0_req = 1; rise_cyc[0] = cyc;
      end
    end
  end

  // Client 1 driver
  initial begin
    job_t j;
    c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) c1_req = 0;
      else if (c1_req) begin
        if (c1_ack) c1_req = 0;
      end else if (jq1.size() > 0) begin
        j = jq1.pop_front();
        c1_we = j.we; c1_addr = j.addr; c1_wdata = j.wdata;
        c1_req = 1; rise_cyc[1] = cyc;
      end
    end
  end

  // SRAM controller model: answers mdl_delay cycles after the command pulse.
  initial begin
    int d;
    int spur_done;
    spur_done = 0;
    mem_ready = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && (mem_read_req || mem_write_req)) begin
        d = mdl_delay;
        if (d != 0) begin
          for (int i = 0; i < d; i++) begin
            @(negedge clk);
            if (!rst_n) break;
          end
          if (rst_n) begin
            mem_ready = 1; mem_rdata = mdl_rdata;
            @(negedge clk);
            mem_ready = 0;
          end
        end
      end else if (spur_cnt != spur_done) begin
        spur_done = spur_cnt;
        mem_ready = 1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_ready = 0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    bit   pulse;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0; rd_cnt = 0; wr_cnt = 0;
      end else begin
        pulse = mem_read_req || mem_write_req;
        if (mem_read_req && mem_write_req) chk("both_mem_req", 1, 0);
        if (pulse) begin
          if (sb.size() == 0) chk("unexpected_mem_req", 1, 0);
          else begin
            chk("req_type_we", mem_write_req, sb[0].we);
            if (sb[0].lat1) chk("grant_latency", cyc - rise_cyc[sb[0].cl], 1);
          end
          issue_cyc = cyc; busy = 1;
          if (mem_read_req) rd_cnt++;
          if (mem_write_req) wr_cnt++;
        end
        if (busy && sb.size() > 0) begin
          chk("mem_addr", mem_addr, sb[0].addr);
          chk("mem_wdata", mem_wdata, sb[0].wdata);
        end
        if (c0_ack && c1_ack) chk("double_ack", 1, 0);
        else if (c0_ack || c1_ack) begin
          if (sb.size() == 0) chk("unexpected_ack", 1, 0);
          else begin
            e = sb.pop_front();
            chk("ack_client", c1_ack, e.cl);
            chk("ack_err", e.cl ? c1_err : c0_err, e.err);
            chk("ack_rdata", e.cl ? c1_rdata : c0_rdata, e.rdata);
            chk("ack_latency", cyc - issue_cyc, e.lat);
            chk("rd_pulses", rd_cnt, e.we ? 0 : 1);
            chk("wr_pulses", wr_cnt, e.we ? 1 : 0);
          end
          busy = 0; rd_cnt = 0; wr_cnt = 0;
        end
      end
    end
  end

  initial begin
    int n;
    //                 cl we addr        wdata     dly rret      err rdata
    tie_rows[0] = '{1'b0, 1'b0, 17'h00100, 16'h0000, 2, 16'h5A5A, 1'b0, 16'h5A5A};
    tie_rows[1] = '{1'b1, 1'b1, 17'h00200, 16'h1111, 2, 16'h5A5A, 1'b0, 16'h0000};
    tie_rows[2] = '{1'b0, 1'b1, 17'h00300, 16'h2222, 2, 16'h5A5A, 1'b0, 16'h5A5A};
    tie_rows[3] = '{1'b1, 1'b0, 17'h00400, 16'h0000, 2, 16'h5A5A, 1'b0, 16'h5A5A};

    rows[0] = '{1'b0, 1'b0, 17'h00010, 16'h0000, 4,  16'hBEEF, 1'b0, 16'hBEEF};
    rows[1] = '{1'b1, 1'b1, 17'h1FFFF, 16'h1234, 3,  16'hFFFF, 1'b0, 16'h5A5A};
    rows[2] = '{1'b0, 1'b0, 17'h0ABCD, 16'h0000, 0,  16'h0000, 1'b1, 16'hBEEF};
    rows[3] = '{1'b0, 1'b0, 17'h00020, 16'h0000, 1,  16'h0F0F, 1'b0, 16'h0F0F};
    rows[4] = '{1'b1, 1'b0, 17'h00000, 16'h0000, 5,  16'hC3C3, 1'b0, 16'hC3C3};
    rows[5] = '{1'b1, 1'b1, 17'h15555, 16'hFFFF, 0,  16'h0000, 1'b1, 16'hC3C3};
    rows[6] = '{1'b0, 1'b0, 17'h1FFFF, 16'h0000, TO, 16'h7777, 1'b0, 16'h7777};
    rows[7] = '{1'b1, 1'b0, 17'h00042, 16'h0000, 2,  16'h2468, 1'b0, 16'h2468};

    rst_n = 1;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_c0_ack", c0_ack, 0);
    chk("rst_c1_ack", c1_ack, 0);
    chk("rst_errs", {c0_err, c1_err}, 0);
    chk("rst_mem_reqs", {mem_read_req, mem_write_req}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", {c0_rdata, c1_rdata}, 0);
    rst_n = 1;

    // Simultaneous requests straight after reset: grants 0,1,0,1.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) run_row(tie_rows[i], (i == 0));
    wait_idle(200);

    // Single-client transactions.
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      run_row(rows[i], 1'b1);
      wait_idle(4 * TO + 40);
    end

    // Stray mem_ready while idle must be ignored.
    spur_cnt++;
    repeat (4) @(negedge clk);
    chk("spur_c0_rdata", c0_rdata, 16'h7777);
    chk("spur_c1_rdata", c1_rdata, 16'hC3C3);
    chk("spur_mem_reqs", {mem_read_req, mem_write_req}, 0);
    @(posedge clk); #1;
    run_row(rows[7], 1'b1);
    wait_idle(4 * TO + 40);

    // Reset in the middle of WAIT aborts without an ack.
    @(posedge clk); #1;
    run_row('{1'b0, 1'b0, 17'h00055, 16'h0000, 0, 16'h0000, 1'b0, 16'h0000}, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_read_req && n < 20);
    chk("abort_txn_issued", mem_read_req, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_acks", {c0_ack, c1_ack}, 0);
    chk("mid_rst_mem_reqs", {mem_read_req, mem_write_req}, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_rdata", {c0_rdata, c1_rdata}, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    chk("in_rst_acks", {c0_ack, c1_ack}, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    run_row('{1'b0, 1'b0, 17'h00066, 16'h0000, 2, 16'h1357, 1'b0, 16'h1357}, 1'b1);
    wait_idle(4 * TO + 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 Parameter ADDR_W, default 17: SRAM word-address width.
REQ-002 Parameter DATA_W, default 16: SRAM data width.
REQ-003 Parameter TIMEOUT, default 64: maximum WAIT cycles before the transaction is abandoned.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cN_req  in  1 (N=0,1)  client request level; held high until cN_ack, dropped the cycle after cN_ack.
REQ-007 cN_we  in  1  1=write, 0=read; stable while cN_req is high.
REQ-008 cN_addr  in  ADDR_W  word address; stable while cN_req is high.
REQ-009 cN_wdata  in  DATA_W  write data; stable while cN_req is high.
REQ-010 cN_ack  out  1  one-cycle completion pulse.
REQ-011 cN_rdata  out  DATA_W  read data, valid when cN_ack is high, held afterwards.
REQ-012 cN_err  out  1  qualifies cN_ack; 1 = timeout.
REQ-013 mem_read_req, mem_write_req  out  1  one-cycle request pulses to the SRAM controller.
REQ-014 mem_addr  out  ADDR_W, mem_wdata  out  DATA_W  registered transaction address and data.
REQ-015 mem_rdata  in  DATA_W, mem_ready  in  1  controller read data and one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE.
REQ-017 IDLE: if any cN_req is high, grant one client, register its we/addr/wdata into mem_addr/mem_wdata and an internal we bit, then go to ISSUE.
REQ-018 Arbitration: if only one client requests, grant it; if both request, grant the client not granted last (round-robin); last_grant resets to 1, so client 0 wins the first tie.
REQ-019 ISSUE: assert exactly one of mem_read_req or mem_write_req for exactly one cycle, then go to WAIT with the wait counter cleared.
REQ-020 WAIT: on mem_ready=1, register mem_rdata into the granted cN_rdata on reads only, then go to DONE.
REQ-021 WAIT timeout: if the counter reaches TIMEOUT with no mem_ready, set the error flag, leave cN_rdata unchanged and go to DONE.
REQ-022 DONE: pulse the granted cN_ack for one cycle, with cN_err reflecting the error flag, then return to IDLE.
REQ-023 mem_ready outside WAIT SHALL be ignored.
REQ-024 mem_addr and mem_wdata SHALL stay constant from ISSUE through DONE.
REQ-025 Latency: cN_req rising in IDLE at cycle 0 gives ISSUE at cycle 1; mem_ready at cycle k gives cN_ack at cycle k+1.
REQ-026 Back-to-back requests: IDLE is re-entered one cycle after DONE, and a still-pending client is granted in that cycle.
REQ-027 The wait counter SHALL be ceil(log2(TIMEOUT+1)) bits wide and SHALL saturate.
REQ-028 At most one transaction SHALL be outstanding; a request arriving mid-transaction waits.

Reset
REQ-029 On rst_n low, asynchronously: state=IDLE; all ack, err and mem_*_req outputs 0; mem_addr, mem_wdata and cN_rdata 0; counter 0; last_grant=1.
REQ-030 Reset asserted mid-transaction SHALL abort it without an ack; the client re-requests after reset.

Structure
REQ-031 Package sram_arb_pkg SHALL hold the state enum, ADDR_W/DATA_W defaults and the client-index type.
REQ-032 Two-way round-robin selection SHALL be a sub-module, sram_arb_rr (inputs: req[1:0], last_grant; outputs: grant_valid, grant_idx).

Verification
REQ-033 c0 reads 0x00010 and the model returns mem_ready 4 cycles after ISSUE with 0xBEEF -> one mem_read_req pulse, mem_addr=0x00010, c0_ack one cycle after mem_ready, c0_rdata=0xBEEF, c0_err=0.
REQ-034 c1 writes 0x1FFFF/0x1234 -> one mem_write_req pulse, mem_wdata=0x1234 stable until ack, c1_ack=1, c1_rdata unchanged.
REQ-035 c0 and c1 request in the same cycle after reset -> c0 granted first, c1 second; held continuously, grants alternate 0,1,0,1.
REQ-036 Model never asserts mem_ready -> c0_ack with c0_err=1 exactly TIMEOUT+1 cycles after ISSUE; the next request completes normally.
REQ-037 rst_n pulsed low during WAIT -> all outputs return to reset values immediately, no ack; a new request after reset completes.
REQ-038 Spurious mem_ready in IDLE -> no ack and no state change.
